// File: rtl/jac_pkg.sv
// Shared constants for the Jac1-8 control unit: widths, opcodes, FSM states,
// flag bit positions and instruction field positions.
package jac_pkg;

  localparam int DataWidth     = 8;
  localparam int NumOpCodeBits = 5;
  localparam int ParamBits     = 8;
  localparam int NumStatusBits = 3;
  localparam int PcWidth       = 8;
  localparam int InstrWidth    = 16;
  localparam int NumRegs       = 8;
  localparam int RsBits        = $clog2(NumRegs);

  localparam logic [NumOpCodeBits-1:0] Op_NOP = 5'h00;
  localparam logic [NumOpCodeBits-1:0] Op_ADD = 5'h01;
  localparam logic [NumOpCodeBits-1:0] Op_SUB = 5'h02;
  localparam logic [NumOpCodeBits-1:0] Op_AND = 5'h03;
  localparam logic [NumOpCodeBits-1:0] Op_OR  = 5'h04;
  localparam logic [NumOpCodeBits-1:0] Op_NOT = 5'h05;
  localparam logic [NumOpCodeBits-1:0] Op_SHL = 5'h06;
  localparam logic [NumOpCodeBits-1:0] Op_SHR = 5'h07;
  localparam logic [NumOpCodeBits-1:0] Op_VAL = 5'h08;
  localparam logic [NumOpCodeBits-1:0] Op_STA = 5'h09;
  localparam logic [NumOpCodeBits-1:0] Op_LDR = 5'h0A;
  localparam logic [NumOpCodeBits-1:0] Op_JMP = 5'h10;
  localparam logic [NumOpCodeBits-1:0] Op_JZ  = 5'h11;
  localparam logic [NumOpCodeBits-1:0] Op_JC  = 5'h12;
  localparam logic [NumOpCodeBits-1:0] Op_HLT = 5'h1F;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 2;

  // Instruction layout: opcode[15:11] rs[10:8] param[7:0]
  localparam int OpcodeMsb = 15;
  localparam int OpcodeLsb = 11;
  localparam int RsMsb     = 10;
  localparam int RsLsb     = 8;
  localparam int ParamMsb  = 7;
  localparam int ParamLsb  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [NumOpCodeBits-1:0] op);
    return (op >= Op_ADD) && (op <= Op_VAL);
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// General-purpose register file: combinational read, synchronous write,
// synchronous clear.
module jac_regfile #(
  parameter int NumRegs   = 8,
  parameter int DataWidth = 8,
  parameter int AddrBits  = $clog2(NumRegs)
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [AddrBits-1:0]  raddr,
  output logic [DataWidth-1:0] rdata,
  input  logic                 we,
  input  logic [AddrBits-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata
);

  logic [DataWidth-1:0] regs_reg [NumRegs];
  logic [NumRegs-1:0]   we_vec;

  generate
    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_we
      assign we_vec[gi] = we && (waddr == AddrBits'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumRegs; i++) begin
      if (srst) begin
        regs_reg[i] <= '0;
      end else if (we_vec[i]) begin
        regs_reg[i] <= wdata;
      end
    end
  end

  assign rdata = regs_reg[raddr];

endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 fetch/decode/execute sequencer: owns PC, accumulator, flags and the
// register file, and drives the external combinational ALU.
module jac_control_unit
  import jac_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [PcWidth-1:0]       imem_addr,
  input  logic [InstrWidth-1:0]    imem_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [DataWidth-1:0]     acc,
  output logic [NumStatusBits-1:0] flags,
  output logic [PcWidth-1:0]       pc,
  output logic                     halted
);

  state_t                   state_reg, state_next;
  logic [PcWidth-1:0]       pc_reg, pc_next;
  logic [DataWidth-1:0]     acc_reg, acc_next;
  logic [NumStatusBits-1:0] flags_reg, flags_next;
  logic [InstrWidth-1:0]    ir_reg, ir_next;

  logic [NumOpCodeBits-1:0] ir_opcode;
  logic [RsBits-1:0]        ir_rs;
  logic [ParamBits-1:0]     ir_param;
  logic [DataWidth-1:0]     rf_rdata;
  logic                     rf_we;

  assign ir_opcode = ir_reg[OpcodeMsb:OpcodeLsb];
  assign ir_rs     = ir_reg[RsMsb:RsLsb];
  assign ir_param  = ir_reg[ParamMsb:ParamLsb];

  jac_regfile #(
    .NumRegs   (NumRegs),
    .DataWidth (DataWidth)
  ) u_regfile (
    .clk   (clk),
    .srst  (reset),
    .raddr (ir_rs),
    .rdata (rf_rdata),
    .we    (rf_we),
    .waddr (ir_rs),
    .wdata (acc_reg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      acc_reg   <= '0;
      flags_reg <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      acc_reg   <= acc_next;
      flags_reg <= flags_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    acc_next   = acc_reg;
    flags_next = flags_reg;
    ir_next    = ir_reg;
    alu_opcode = Op_NOP;
    rf_we      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ir_next    = imem_data;
        state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_next = ST_FETCH;
        pc_next    = pc_reg + 1'b1;
        if (is_alu_op(ir_opcode)) begin
          alu_opcode = ir_opcode;
          acc_next   = alu_result;
          flags_next = alu_status;
        end else begin
          // Jumps see flags_reg, i.e. the flags left by the previous instruction
          case (ir_opcode)
            Op_STA: rf_we = 1'b1;
            Op_LDR: begin
              acc_next           = rf_rdata;
              flags_next[FLAG_Z] = (rf_rdata == '0);
            end
            Op_JMP: pc_next = PcWidth'(ir_param);
            Op_JZ:  if (flags_reg[FLAG_Z]) pc_next = PcWidth'(ir_param);
            Op_JC:  if (flags_reg[FLAG_C]) pc_next = PcWidth'(ir_param);
            Op_HLT: begin
              pc_next    = pc_reg;
              state_next = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // pc only changes at the end of EXECUTE, so it is stable throughout FETCH
  assign imem_addr    = pc_reg;
  assign alu_operand1 = acc_reg;
  assign alu_operand2 = rf_rdata;
  assign alu_param    = ir_param;
  assign acc          = acc_reg;
  assign flags        = flags_reg;
  assign pc           = pc_reg;
  assign halted       = (state_reg == ST_HALT);

endmodule
